// File: rtl/montar_pin.sv
// -----------------------------------------------------------------------------
// montar_pin
// Keypad-to-PIN assembler that sits in front of the PIN checker. It collects
// decoded keypad strokes into a 4-digit PIN, publishes the PIN with a
// one-cycle status strobe when ENTER is pressed, and handles CLEAR, an
// inactivity timeout and an external enable (lockout) gate.
//
// Ports
//   clk          in   1   clock
//   rst          in   1   reset, asynchronous, active-high
//   enable       in   1   1 = accept keys, 0 = ignore key_valid
//   key_valid    in   1   single-cycle strobe, key_code valid this cycle
//   key_code     in   4   0-9 digit, 4'hA = CLEAR, 4'hB = ENTER, others ignored
//   pin_out      out  17  {status, digit1, digit2, digit3, digit4}
//   digit_count  out  3   digits currently held (0..4)
//   timeout_evt  out  1   one-cycle pulse when an entry is discarded by timeout
// -----------------------------------------------------------------------------
module montar_pin #(
    parameter int          TIMEOUT_CYCLES = 5_000_000,
    parameter logic [3:0]  PAD_DIGIT      = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [16:0] pin_out,
    output logic [2:0]  digit_count,
    output logic        timeout_evt
);

    localparam int              TW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COLETA = 2'd1;
    localparam logic [1:0] S_ENVIA  = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    localparam logic [3:0][3:0] PAD_ALL = {4{PAD_DIGIT}};

    // digits_q[0] holds digit1 (the first key pressed)
    logic [1:0]       state_q,  state_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic [2:0]       count_q,  count_d;
    logic [TW-1:0]    timer_q,  timer_d;
    logic             status_q, status_d;
    logic             tevt_q,   tevt_d;

    logic key_acc_s;
    logic is_digit_s;
    logic is_clear_s;
    logic is_enter_s;

    assign key_acc_s  = key_valid & enable;
    assign is_digit_s = key_acc_s & (key_code <= 4'd9);
    assign is_clear_s = key_acc_s & (key_code == KEY_CLEAR);
    assign is_enter_s = key_acc_s & (key_code == KEY_ENTER);

    // Next-state logic for the entry FSM, digit store, counter and idle timer
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        timer_d  = timer_q;
        status_d = 1'b0;
        tevt_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                digits_d = PAD_ALL;
                count_d  = 3'd0;
                timer_d  = '0;
                if (is_digit_s) begin
                    digits_d[0] = key_code;
                    count_d     = 3'd1;
                    state_d     = S_COLETA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLETA: begin
                // An accepted key always takes priority over the timeout check,
                // so a key landing in the timeout cycle keeps the entry alive.
                if (is_digit_s) begin
                    timer_d = '0;
                    if (count_q < 3'd4) begin
                        digits_d[count_q[1:0]] = key_code;
                        count_d                = count_q + 3'd1;
                    end else begin
                        count_d = count_q;
                    end
                end else if (is_clear_s) begin
                    digits_d = PAD_ALL;
                    count_d  = 3'd0;
                    timer_d  = '0;
                    state_d  = S_IDLE;
                end else if (is_enter_s) begin
                    status_d = 1'b1;
                    timer_d  = '0;
                    state_d  = S_ENVIA;
                end else if (timer_q >= T_LAST) begin
                    digits_d = PAD_ALL;
                    count_d  = 3'd0;
                    timer_d  = '0;
                    tevt_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    // Never exceeds T_LAST, so the counter cannot wrap
                    timer_d = timer_q + TW'(1);
                end
            end
            S_ENVIA: begin
                timer_d = '0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // Digits stay stable through HOLD; padding happens on IDLE entry
                timer_d  = '0;
                digits_d = PAD_ALL;
                count_d  = 3'd0;
                state_d  = S_IDLE;
            end
            default: begin
                digits_d = PAD_ALL;
                count_d  = 3'd0;
                timer_d  = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            digits_q <= PAD_ALL;
            count_q  <= 3'd0;
            timer_q  <= '0;
            status_q <= 1'b0;
            tevt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            status_q <= status_d;
            tevt_q   <= tevt_d;
        end
    end

    assign pin_out     = {status_q, digits_q[0], digits_q[1], digits_q[2], digits_q[3]};
    assign digit_count = count_q;
    assign timeout_evt = tevt_q;

endmodule

// File: tb/tb_montar_pin.sv
module tb_montar_pin;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [16:0] pin_out;
    logic [2:0]  digit_count;
    logic        timeout_evt;

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[$];

    localparam logic [16:0] IDLE_PIN = 17'h0FFFF;

    montar_pin #(.TIMEOUT_CYCLES(16), .PAD_DIGIT(4'hF)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pin_out     (pin_out),
        .digit_count (digit_count),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one key strobe; returns on the negedge after it was sampled
    task automatic key(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    // ENTER with an expected PIN pushed to the scoreboard, then check pulse/HOLD/IDLE
    task automatic enter_expect(input logic [15:0] digs);
        exp_q.push_back({1'b1, digs});
        key(4'hB);
        chk("status_pulse", {16'h0, pin_out[16]}, 17'h1);
        @(negedge clk);
        chk("hold_state", pin_out, {1'b0, digs});
        @(negedge clk);
        chk("idle_pad", pin_out, IDLE_PIN);
        chk("idle_count", {14'h0, digit_count}, 17'h0);
    endtask

    // Scoreboard: every status pulse must match the oldest expected PIN
    always @(negedge clk) begin
        if (!rst && pin_out[16]) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", pin_out, 17'h0);
            end else begin
                chk("sb_pin", pin_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
        chk("reset_pin", pin_out, IDLE_PIN);
        chk("reset_count", {14'h0, digit_count}, 17'h0);
        chk("reset_tevt", {16'h0, timeout_evt}, 17'h0);
        rst = 1'b0;
        @(negedge clk);

        // 1: 1,2,3,4,ENTER
        for (int i = 1; i <= 4; i++) begin
            key(4'(i));
            chk("count_up", {14'h0, digit_count}, 17'(i));
        end
        enter_expect(16'h1234);

        // 2: short entry padded, overlong entry truncated
        key(4'h7);
        enter_expect(16'h7FFF);
        for (int i = 1; i <= 6; i++) key(4'(i));
        chk("count_sat", {14'h0, digit_count}, 17'h4);
        enter_expect(16'h1234);

        // 3: CLEAR discards; ENTER in IDLE does nothing
        key(4'h5);
        key(4'h5);
        key(4'hA);
        chk("clear_count", {14'h0, digit_count}, 17'h0);
        chk("clear_pin", pin_out, IDLE_PIN);
        key(4'hB);
        @(negedge clk);
        chk("enter_idle", pin_out, IDLE_PIN);

        // 4: timeout after 16 idle cycles
        key(4'h9);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("no_tevt_early", {16'h0, timeout_evt}, 17'h0);
        end
        @(negedge clk);
        chk("tevt_fire", {16'h0, timeout_evt}, 17'h1);
        chk("tevt_count", {14'h0, digit_count}, 17'h0);
        chk("tevt_pin", pin_out, IDLE_PIN);
        @(negedge clk);
        chk("tevt_one_cycle", {16'h0, timeout_evt}, 17'h0);

        // 4b: key on cycle 15 restarts the timer
        key(4'h9);
        repeat (14) @(negedge clk);
        key(4'h8);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            chk("no_tevt_restart", {16'h0, timeout_evt}, 17'h0);
        end
        chk("restart_count", {14'h0, digit_count}, 17'h2);
        key(4'hA);

        // 5: enable gate
        enable = 1'b0;
        key(4'h1);
        key(4'h2);
        chk("gated_count", {14'h0, digit_count}, 17'h0);
        enable = 1'b1;
        key(4'h3);
        enter_expect(16'h3FFF);

        // 6: asynchronous reset mid-entry
        key(4'h1);
        key(4'h2);
        chk("pre_rst_count", {14'h0, digit_count}, 17'h2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pin", pin_out, IDLE_PIN);
        chk("async_rst_count", {14'h0, digit_count}, 17'h0);
        @(negedge clk);
        rst = 1'b0;
        key(4'h4);
        key(4'h3);
        key(4'h2);
        key(4'h1);
        enter_expect(16'h4321);

        repeat (3) @(negedge clk);
        chk("sb_drained", 17'(exp_q.size()), 17'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
